// File: rtl/morra_cinese_if.sv
// Move/command and result signals of the morra_cinese game block.
interface morra_cinese_if;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic       INIZIA;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  modport master (output PRIMO, SECONDO, INIZIA, input MANCHE, PARTITA);
  modport slave  (input PRIMO, SECONDO, INIZIA, output MANCHE, PARTITA);
endinterface

// File: rtl/morra_cinese.sv
// Rock-paper-scissors referee: scores manches, enforces the no-repeat rule
// for the last winner and decides the game outcome.
module morra_cinese (
  input  logic           clk,
  input  logic           rst_n,
  morra_cinese_if.slave  bus
);

  localparam int unsigned CW = 5;
  localparam logic [1:0] MV_NONE = 2'b00;
  localparam logic [1:0] MV_ROCK = 2'b01;
  localparam logic [1:0] MV_PAPR = 2'b10;
  localparam logic [1:0] MV_SCIS = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_END} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] max_q, max_d;
  logic [CW-1:0] played_q, played_d;
  logic [CW-1:0] w1_q, w1_d;
  logic [CW-1:0] w2_q, w2_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_p2_q, mem_p2_d;
  logic [1:0]    mem_move_q, mem_move_d;
  logic [1:0]    manche_q, manche_d;
  logic [1:0]    partita_q, partita_d;

  logic          is_draw_c;
  logic          p1_beats_c;
  logic          blocked_c;
  logic          valid_c;
  logic          lead2_c;

  assign bus.MANCHE  = manche_q;
  assign bus.PARTITA = partita_q;

  // An equal-move manche is always a valid draw; the repeat ban only
  // blocks a manche that would otherwise produce a winner.
  always_comb begin
    is_draw_c  = (bus.PRIMO == bus.SECONDO);
    p1_beats_c = ((bus.PRIMO == MV_ROCK) && (bus.SECONDO == MV_SCIS)) ||
                 ((bus.PRIMO == MV_SCIS) && (bus.SECONDO == MV_PAPR)) ||
                 ((bus.PRIMO == MV_PAPR) && (bus.SECONDO == MV_ROCK));
    blocked_c  = mem_valid_q && !is_draw_c &&
                 (mem_p2_q ? (bus.SECONDO == mem_move_q) : (bus.PRIMO == mem_move_q));
    valid_c    = (bus.PRIMO != MV_NONE) && (bus.SECONDO != MV_NONE) && !blocked_c;
  end

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    played_d    = played_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    mem_valid_d = mem_valid_q;
    mem_p2_d    = mem_p2_q;
    mem_move_d  = mem_move_q;
    manche_d    = 2'b00;
    partita_d   = 2'b00;
    lead2_c     = 1'b0;

    if (bus.INIZIA) begin
      state_d     = S_PLAY;
      max_d       = CW'({bus.PRIMO, bus.SECONDO}) + CW'(4);
      played_d    = '0;
      w1_d        = '0;
      w2_d        = '0;
      mem_valid_d = 1'b0;
      mem_p2_d    = 1'b0;
      mem_move_d  = MV_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_PLAY: begin
          if (valid_c) begin
            played_d = played_q + CW'(1);
            if (is_draw_c) begin
              manche_d    = 2'b11;
              mem_valid_d = 1'b0;
            end else if (p1_beats_c) begin
              manche_d    = 2'b01;
              w1_d        = w1_q + CW'(1);
              mem_valid_d = 1'b1;
              mem_p2_d    = 1'b0;
              mem_move_d  = bus.PRIMO;
            end else begin
              manche_d    = 2'b10;
              w2_d        = w2_q + CW'(1);
              mem_valid_d = 1'b1;
              mem_p2_d    = 1'b1;
              mem_move_d  = bus.SECONDO;
            end
            // Widened compare so the +2 margin cannot overflow.
            lead2_c = ((CW+1)'(w1_d) >= (CW+1)'(w2_d) + (CW+1)'(2)) ||
                      ((CW+1)'(w2_d) >= (CW+1)'(w1_d) + (CW+1)'(2));
            if (((played_d >= CW'(4)) && lead2_c) || (played_d == max_q)) begin
              state_d = S_END;
              if (w1_d > w2_d)      partita_d = 2'b01;
              else if (w2_d > w1_d) partita_d = 2'b10;
              else                  partita_d = 2'b11;
            end
          end
        end
        S_END:   partita_d = partita_q;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      max_q       <= '0;
      played_q    <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_p2_q    <= 1'b0;
      mem_move_q  <= MV_NONE;
      manche_q    <= 2'b00;
      partita_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      played_q    <= played_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      mem_valid_q <= mem_valid_d;
      mem_p2_q    <= mem_p2_d;
      mem_move_q  <= mem_move_d;
      manche_q    <= manche_d;
      partita_q   <= partita_d;
    end
  end

endmodule

// File: tb/tb_morra_cinese.sv
// Directed scoreboard bench for morra_cinese: the driver queues expected
// results per issued cycle, the monitor checks them after each rising edge.
module tb_morra_cinese;

  logic clk;
  logic rst_n;
  morra_cinese_if bus ();

  morra_cinese dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] m;
    logic [1:0] p;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [1:0] em, input logic [1:0] ep);
    n_cmp++;
    if (bus.MANCHE !== em || bus.PARTITA !== ep) begin
      n_err++;
      $display("FAIL %s: got MANCHE=%b PARTITA=%b, expected MANCHE=%b PARTITA=%b",
               tag, bus.MANCHE, bus.PARTITA, em, ep);
    end
  endtask

  // One clocked cycle of stimulus plus its expected registered result.
  task automatic step(input logic ini, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] em, input logic [1:0] ep, input string tag);
    exp_t e;
    @(negedge clk);
    bus.INIZIA  = ini;
    bus.PRIMO   = a;
    bus.SECONDO = b;
    e.m = em;
    e.p = ep;
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e.tag, e.m, e.p);
      end
    end
  end

  initial begin : driver
    rst_n       = 1'b0;
    bus.INIZIA  = 1'b0;
    bus.PRIMO   = 2'b00;
    bus.SECONDO = 2'b00;
    #1;
    compare("reset_state", 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 2'b01, 2'b10, 2'b00, 2'b00, "idle_no_game");

    // Max 13 game with invalid, win, draw and repeat-exempt draw manches.
    step(1'b1, 2'b10, 2'b01, 2'b00, 2'b00, "g1_start");
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "g1_m1_none");
    step(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, "g1_m2_p1");
    step(1'b0, 2'b11, 2'b01, 2'b10, 2'b00, "g1_m3_p2");
    step(1'b0, 2'b00, 2'b10, 2'b00, 2'b00, "g1_m4_none");
    step(1'b0, 2'b01, 2'b01, 2'b11, 2'b00, "g1_m5_draw");
    step(1'b0, 2'b01, 2'b01, 2'b11, 2'b00, "g1_m6_draw");
    step(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, "g1_m7_p1");

    // Asynchronous reset between edges during PLAY.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare("async_reset_midgame", 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "post_reset_idle_a");
    step(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, "post_reset_idle_b");

    // Repeat rule after a win, and after a draw.
    step(1'b1, 2'b10, 2'b01, 2'b00, 2'b00, "g2_start");
    step(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, "g2_p1_paper");
    step(1'b0, 2'b10, 2'b11, 2'b00, 2'b00, "g2_p1_repeat_blocked");
    step(1'b0, 2'b01, 2'b01, 2'b11, 2'b00, "g2_draw");
    step(1'b0, 2'b01, 2'b01, 2'b11, 2'b00, "g2_draw_again");

    // Max 5, early end on a two-win lead after four manches.
    step(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, "g3_start");
    step(1'b0, 2'b01, 2'b10, 2'b10, 2'b00, "g3_m1");
    step(1'b0, 2'b11, 2'b01, 2'b10, 2'b00, "g3_m2");
    step(1'b0, 2'b10, 2'b11, 2'b10, 2'b00, "g3_m3");
    step(1'b0, 2'b11, 2'b10, 2'b01, 2'b10, "g3_m4_end_p2");
    step(1'b0, 2'b01, 2'b10, 2'b00, 2'b10, "g3_end_hold_a");
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b10, "g3_end_hold_b");

    // Restart from END, then restart mid-game with P1 leading; max 4 draw.
    step(1'b1, 2'b10, 2'b01, 2'b00, 2'b00, "g4_start_from_end");
    step(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, "g4_p1_lead");
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, "g5_restart_midgame");
    step(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, "g5_m1_p1");
    step(1'b0, 2'b01, 2'b10, 2'b10, 2'b00, "g5_m2_p2");
    step(1'b0, 2'b01, 2'b11, 2'b01, 2'b00, "g5_m3_p1");
    step(1'b0, 2'b11, 2'b01, 2'b10, 2'b11, "g5_m4_max_draw");
    step(1'b0, 2'b11, 2'b11, 2'b00, 2'b11, "g5_end_hold");
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, "g5_end_hold_b");

    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    #4;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/morra_cinese.md
MORRA_CINESE -- requirements
Module: morra_cinese

Interface
REQ-001 The interface SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 PRIMO  input  2  player-1 move (00 none, 01 rock, 10 paper, 11 scissors); high half of the manche limit when INIZIA=1.
REQ-005 SECONDO  input  2  player-2 move, same encoding; low half of the manche limit when INIZIA=1.
REQ-006 INIZIA  input  1  1 = start/restart game, 0 = play a manche.
REQ-007 MANCHE  output  2  registered manche result (00 invalid, 01 P1 won, 10 P2 won, 11 draw).
REQ-008 PARTITA  output  2  registered game result (00 not ended, 01 P1 winner, 10 P2 winner, 11 draw).

Function
REQ-009 Inputs SHALL be sampled on every rising clk edge; MANCHE/PARTITA SHALL update on that same edge (1-cycle latency) and hold between edges.
REQ-010 States: IDLE (no game configured), PLAY (game in progress), END (game finished).
REQ-011 INIZIA=1 in any state SHALL go to PLAY, set max = {PRIMO,SECONDO} + 4 (5-bit, range 4..19), clear played count, both win counters and last-winning-move memory, and output MANCHE=00, PARTITA=00.
REQ-012 In IDLE with INIZIA=0: stay IDLE, outputs 00/00.
REQ-013 In PLAY with INIZIA=0, a manche SHALL be invalid if either move is 00, or the winner of the previous valid non-draw manche repeats the move it won with.
REQ-014 Invalid manche: MANCHE=00; counters, played count and move memory unchanged; PARTITA=00.
REQ-015 Valid manche: rock beats scissors, scissors beat paper, paper beats rock, equal moves draw; MANCHE=01/10/11 accordingly; played count +1; winner's counter +1.
REQ-016 Move memory: after a non-draw, store winner identity and its move; a draw clears the restriction.
REQ-017 After each valid manche, the game SHALL end if (played >= 4 and |P1 wins - P2 wins| >= 2) or played == max.
REQ-018 On end, PARTITA = the player with more wins (01/10), or 11 if equal; MANCHE still reports that final manche; next state END.
REQ-019 Otherwise PARTITA=00 and the state stays PLAY.
REQ-020 In END with INIZIA=0: inputs ignored, MANCHE=00, PARTITA holds the final result.
REQ-021 Win and played counters SHALL be 5 bits and never wrap (max 19 manches).

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, MANCHE=00, PARTITA=00, max=0, all counters and move memory cleared, regardless of clk.
REQ-023 Reset release mid-game SHALL leave the block in IDLE; a new INIZIA is required before manches count.

Verification
REQ-024 INIZIA=1, PRIMO=10, SECONDO=01 (max 13), then manches (00,00),(10,01),(11,01),(00,10),(01,01),(01,01),(10,01) -> MANCHE 00,01,10,00,11,11,01; PARTITA 00 throughout.
REQ-025 INIZIA=1, PRIMO=00, SECONDO=01 (max 5), then (01,10),(11,01),(10,11),(11,10) -> MANCHE 10,10,10,01; PARTITA 00,00,00,10; next cycle with any moves -> MANCHE 00, PARTITA 10.
REQ-026 Repeat rule: after (10,01) P1 wins, (10,11) -> MANCHE 00 and no count; after a draw (01,01) then (01,01) -> MANCHE 11 (valid).
REQ-027 Max reached as draw: max 4, manches P1, P2, P1, P2 -> fourth cycle MANCHE 10, PARTITA 11.
REQ-028 Reset mid-game: drop rst_n between clock edges during PLAY -> outputs 00/00 immediately; subsequent INIZIA=0 manches -> MANCHE 00.
REQ-029 Restart mid-game: INIZIA=1 in PLAY with P1 leading 1-0 -> outputs 00/00, counters cleared; next manches counted from 0-0.
